// File: rtl/pid_core_param.sv
// Multi-cycle PID core: one shared signed multiplier steps through P, I and D terms per sample.
// Define PID_ANTIWINDUP_EN to enable conditional integration while the output is saturated.
module pid_core_param #(
    parameter int DATA_W = 8,
    parameter int GAIN_W = 8,
    parameter int FRAC_W = 4,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] feedback,
    input  logic [GAIN_W-1:0] kp,
    input  logic [GAIN_W-1:0] ki,
    input  logic [GAIN_W-1:0] kd,
    output logic [DATA_W-1:0] control_signal,
    output logic              out_valid,
    output logic              busy
);

    localparam int E_W = DATA_W + 1;
    localparam int D_W = DATA_W + 2;
    localparam int M_W = GAIN_W + ACC_W + 1;
    localparam int A_W = GAIN_W + ACC_W + 3;

`ifdef PID_ANTIWINDUP_EN
    localparam bit AW_EN = 1'b1;
`else
    localparam bit AW_EN = 1'b0;
`endif

    localparam logic signed [ACC_W:0]   INT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   INT_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
    localparam logic signed [A_W-1:0]   OUT_MAX = {{(A_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, ERR, MP, MI, MD, OUT} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0]        sp_q, fb_q;
    logic [GAIN_W-1:0]        kp_q, ki_q, kd_q;
    logic signed [E_W-1:0]    e_q, e_prev;
    logic signed [D_W-1:0]    d_q;
    logic signed [ACC_W-1:0]  integral;
    logic signed [A_W-1:0]    acc;
    logic                     sat_hi, sat_lo, clear_pend;

    logic signed [E_W-1:0]    e_new;
    logic signed [D_W-1:0]    d_new;
    logic signed [ACC_W:0]    int_sum;
    logic signed [ACC_W-1:0]  int_next;
    logic                     hold;
    logic [GAIN_W-1:0]        gain_sel;
    logic signed [ACC_W-1:0]  mul_sel;
    logic signed [M_W-1:0]    gain_ext, mul_ext, product;
    logic signed [A_W-1:0]    prod_ext, y;
    logic [DATA_W-1:0]        cs_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ERR;
            ERR:     state_next = MP;
            MP:      state_next = MI;
            MI:      state_next = MD;
            MD:      state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    assign e_new   = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
    assign d_new   = {{(D_W-E_W){e_new[E_W-1]}}, e_new} - {{(D_W-E_W){e_prev[E_W-1]}}, e_prev};
    assign int_sum = {integral[ACC_W-1], integral} + {{(ACC_W+1-E_W){e_new[E_W-1]}}, e_new};

    // Integrator holds only when pushing further into an already-saturated output.
    assign hold = AW_EN && ((sat_hi && !e_new[E_W-1] && (|e_new)) || (sat_lo && e_new[E_W-1]));

    always_comb begin
        int_next = int_sum[ACC_W-1:0];
        if (int_sum > INT_MAX)      int_next = INT_MAX[ACC_W-1:0];
        else if (int_sum < INT_MIN) int_next = INT_MIN[ACC_W-1:0];
    end

    always_comb begin
        gain_sel = '0;
        mul_sel  = '0;
        case (state)
            MP: begin
                gain_sel = kp_q;
                mul_sel  = {{(ACC_W-E_W){e_q[E_W-1]}}, e_q};
            end
            MI: begin
                gain_sel = ki_q;
                mul_sel  = integral;
            end
            MD: begin
                gain_sel = kd_q;
                mul_sel  = {{(ACC_W-D_W){d_q[D_W-1]}}, d_q};
            end
            default: ;
        endcase
    end

    assign gain_ext = {{(M_W-GAIN_W){1'b0}}, gain_sel};
    assign mul_ext  = {{(M_W-ACC_W){mul_sel[ACC_W-1]}}, mul_sel};
    assign product  = gain_ext * mul_ext;
    assign prod_ext = {{(A_W-M_W){product[M_W-1]}}, product};
    assign y        = acc >>> FRAC_W;

    always_comb begin
        cs_next = y[DATA_W-1:0];
        if (y[A_W-1])          cs_next = '0;
        else if (y > OUT_MAX)  cs_next = '1;
    end

    // A clear seen mid-sample is remembered and applied once that sample's result is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q           <= '0;
            fb_q           <= '0;
            kp_q           <= '0;
            ki_q           <= '0;
            kd_q           <= '0;
            e_q            <= '0;
            d_q            <= '0;
            e_prev         <= '0;
            integral       <= '0;
            acc            <= '0;
            sat_hi         <= 1'b0;
            sat_lo         <= 1'b0;
            clear_pend     <= 1'b0;
            control_signal <= '0;
            out_valid      <= 1'b0;
        end else begin
            out_valid <= (state == OUT);
            case (state)
                IDLE: begin
                    if (clear) begin
                        integral   <= '0;
                        e_prev     <= '0;
                        sat_hi     <= 1'b0;
                        sat_lo     <= 1'b0;
                        clear_pend <= 1'b0;
                    end
                    if (start) begin
                        sp_q <= setpoint;
                        fb_q <= feedback;
                        kp_q <= kp;
                        ki_q <= ki;
                        kd_q <= kd;
                    end
                end
                ERR: begin
                    e_q <= e_new;
                    d_q <= d_new;
                    if (!hold) integral <= int_next;
                    if (clear) clear_pend <= 1'b1;
                end
                MP: begin
                    acc <= prod_ext;
                    if (clear) clear_pend <= 1'b1;
                end
                MI, MD: begin
                    acc <= acc + prod_ext;
                    if (clear) clear_pend <= 1'b1;
                end
                OUT: begin
                    control_signal <= cs_next;
                    e_prev         <= e_q;
                    sat_hi         <= !y[A_W-1] && (y > OUT_MAX);
                    sat_lo         <= y[A_W-1];
                    if (clear || clear_pend) begin
                        integral   <= '0;
                        e_prev     <= '0;
                        sat_hi     <= 1'b0;
                        sat_lo     <= 1'b0;
                        clear_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_core_param.sv
// Directed self-checking bench for pid_core_param with hand-computed expected control words.
// Anti-windup expectations follow whether PID_ANTIWINDUP_EN is defined for the build.
module tb_pid_core_param;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic [7:0] setpoint, feedback;
    logic [7:0] kp, ki, kd;
    logic [7:0] control_signal;
    logic       out_valid;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int pulses;

    pid_core_param dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .clear          (clear),
        .setpoint       (setpoint),
        .feedback       (feedback),
        .kp             (kp),
        .ki             (ki),
        .kd             (kd),
        .control_signal (control_signal),
        .out_valid      (out_valid),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issues one sample and checks the 5-clock latency; poke=1 re-strobes start mid-sample, poke=2 pulses clear mid-sample.
    task automatic applyStimulus(input string tag, input logic [7:0] sp, input logic [7:0] fb,
                                 input logic [7:0] gp, input logic [7:0] gi, input logic [7:0] gd,
                                 input logic clr, input int poke, input logic [7:0] expected);
        setpoint = sp;
        feedback = fb;
        kp       = gp;
        ki       = gi;
        kd       = gd;
        clear    = clr;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        checkOutput({tag, "_busy"}, busy, 1);
        for (int i = 1; i <= 5; i++) begin
            if (i == 2 && poke == 1) begin
                start    = 1'b1;
                setpoint = 8'd200;
            end
            if (i == 2 && poke == 2) clear = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            clear = 1'b0;
            if (i == 4) checkOutput({tag, "_early_valid"}, out_valid, 0);
        end
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_ctrl"}, control_signal, expected);
        checkOutput({tag, "_busy_drop"}, busy, 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        setpoint = '0;
        feedback = '0;
        kp       = '0;
        ki       = '0;
        kd       = '0;
        #2;
        checkOutput("reset_ctrl", control_signal, 0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        doReset();

        applyStimulus("p_in_range", 8'd100, 8'd60, 8'd16, 8'd0, 8'd0, 1'b1, 0, 8'd40);
        applyStimulus("p_clamp_lo", 8'd60, 8'd100, 8'd16, 8'd0, 8'd0, 1'b1, 0, 8'd0);
        applyStimulus("p_clamp_hi", 8'd100, 8'd0, 8'd255, 8'd0, 8'd0, 1'b1, 0, 8'd255);

        applyStimulus("i_1", 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 1'b1, 0, 8'd10);
        applyStimulus("i_2", 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 1'b0, 0, 8'd20);
        applyStimulus("i_3", 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 1'b0, 0, 8'd30);
        applyStimulus("i_clear_start", 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 1'b1, 0, 8'd10);
        applyStimulus("i_clear_mid", 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 1'b0, 2, 8'd20);
        applyStimulus("i_after_clear", 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 1'b0, 0, 8'd10);

        doReset();
        applyStimulus("d_first", 8'd20, 8'd0, 8'd0, 8'd0, 8'd16, 1'b0, 0, 8'd20);
        applyStimulus("d_second", 8'd20, 8'd0, 8'd0, 8'd0, 8'd16, 1'b0, 1, 8'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        checkOutput("busy_start_ignored", pulses, 0);

        applyStimulus("aw_1", 8'd100, 8'd0, 8'd0, 8'd16, 8'd0, 1'b1, 0, 8'd100);
        applyStimulus("aw_2", 8'd100, 8'd0, 8'd0, 8'd16, 8'd0, 1'b0, 0, 8'd200);
        applyStimulus("aw_3", 8'd100, 8'd0, 8'd0, 8'd16, 8'd0, 1'b0, 0, 8'd255);
        applyStimulus("aw_4", 8'd100, 8'd0, 8'd0, 8'd16, 8'd0, 1'b0, 0, 8'd255);
`ifdef PID_ANTIWINDUP_EN
        applyStimulus("aw_5", 8'd0, 8'd50, 8'd0, 8'd16, 8'd0, 1'b0, 0, 8'd250);
`else
        applyStimulus("aw_5", 8'd0, 8'd50, 8'd0, 8'd16, 8'd0, 1'b0, 0, 8'd255);
`endif

        // Abort a sample while the FSM sits in MI (two edges after acceptance).
        setpoint = 8'd100;
        feedback = 8'd0;
        kp       = 8'd16;
        ki       = 8'd16;
        kd       = 8'd16;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ctrl", control_signal, 0);
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        checkOutput("abort_no_valid", pulses, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("post_abort", 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 1'b0, 0, 8'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pid_core_param.md
# pid_core_param

Parametrised, multi-cycle PID controller core succeeding the fixed 8-bit `tt_um_pid_controller` datapath. It takes one setpoint/feedback sample per start strobe and computes P, I and D terms through one shared multiplier over a short state machine. It keeps integrator and previous-error state across samples and returns a saturated, unsigned control word with a valid pulse. Runtime gains, fixed-point scaling and optional anti-windup are new relative to the 8-bit design.

## Interface
- `DATA_W`, 8: setpoint, feedback and control width (unsigned).
- `GAIN_W`, 8: gain width (unsigned).
- `FRAC_W`, 4: fractional bits of gains; `2^FRAC_W` means 1.0.
- `ACC_W`, 16: integrator width (signed).
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: sample strobe; accepted only in IDLE.
- `clear` in 1: synchronous; zeroes integrator, previous error and saturation flags.
- `setpoint` in DATA_W: target value.
- `feedback` in DATA_W: measured value.
- `kp`, `ki`, `kd` in GAIN_W each: gains, sampled with `start`.
- `control_signal` out DATA_W: registered control output.
- `out_valid` out 1: one-cycle pulse when `control_signal` updates.
- `busy` out 1: high from sample acceptance until `out_valid`.

## Operation
- States: IDLE → ERR → MP → MI → MD → OUT → IDLE. IDLE leaves only on `start`. All other states advance unconditionally.
- IDLE with `start`: latch `setpoint`, `feedback`, `kp`, `ki` and `kd`.
- ERR:
  - e = sp − fb, signed DATA_W+1.
  - integral = clamp(integral + e) to ±(2^(ACC_W−1)−1).
  - d = e − e_prev, signed DATA_W+2.
- MP: acc = kp·e.
- MI: acc += ki·integral.
- MD: acc += kd·d.
- Multiplier and accumulator widths: one shared signed multiplier, GAIN_W+ACC_W+1 bits. The accumulator is GAIN_W+ACC_W+3 bits, so no overflow is possible.
- OUT:
  - y = acc >>> FRAC_W (arithmetic shift).
  - control_signal = clamp(y, 0, 2^DATA_W−1).
  - e_prev ← e.
  - sat_hi ← (y > 2^DATA_W−1), sat_lo ← (y < 0).
  - Pulse `out_valid`.
- `clear`:
  - In IDLE it takes effect at that edge.
  - During a computation it is applied in OUT, after that sample's result is produced.
  - `clear` and `start` on the same IDLE edge: the clear happens first, and the sample uses zeroed state.
- `start` while `busy` is ignored. It is not queued.
- `control_signal` holds its last value between updates.

## Timing
- Reset values, all asynchronous on `rst_n` low:
  - FSM goes to IDLE.
  - `control_signal`=0, `out_valid`=0, `busy`=0.
  - integral, e_prev, sat_hi and sat_lo are 0.
- Reset mid-computation aborts the sample. No `out_valid` is produced.
- Start accepted at edge k:
  - `busy` is high after edge k.
  - `out_valid` and the new `control_signal` appear after edge k+5, and `busy` drops at that same edge.
- Fixed latency: 5 clocks. Maximum throughput is one sample per 6 clocks; `start` is accepted again at edge k+6.
- The first sample after reset or `clear` uses e_prev=0, so d = e.

## Configuration
- `PID_ANTIWINDUP_EN` defined: conditional integration.
  - In ERR, the integrator holds its value when the previous output was saturated in the direction of e: sat_hi with e>0, or sat_lo with e<0.
  - The clamp still applies.
- `PID_ANTIWINDUP_EN` undefined: the integrator always accumulates, limited only by the ACC_W clamp. sat_hi and sat_lo are still computed but are unused.

## Test plan
Default parameters throughout.
- Proportional, in range: kp=16, ki=kd=0, sp=100, fb=60 → `control_signal`=40, with `out_valid` exactly 5 clocks after the start edge.
- Proportional, clamped: kp=16, sp=60, fb=100 → 0. kp=255, sp=100, fb=0 → 255 (1593 clamped).
- Integral: ki=16, kp=kd=0, sp=10, fb=0, three samples → 10, 20, 30. Then `clear` and one more sample → 10.
- Derivative: kd=16, kp=ki=0, after reset sp=20, fb=0 twice → 20, then 0. `start` pulsed while `busy` is ignored, with no extra `out_valid`.
- Anti-windup: ki=16, e=+100 for four samples, then sp=0, fb=50.
  - With `PID_ANTIWINDUP_EN` → 100, 200, 255, 255, 250.
  - Without it → 100, 200, 255, 255, 255.
- Reset mid-operation: assert `rst_n` low in state MI → all outputs 0 and the FSM in IDLE. The next sample computes from zeroed state.
